vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Free-running VGA raster generator. Sits directly upstream of the display read-address/window stage.
- Drives X_CUR_COORD/Y_CUR_COORD consumed by that stage, plus HSYNC, VSYNC, BLANK_N and a frame marker for the DAC and control logic.
- Default timing is 640x480@60 Hz with a 25 MHz pixel rate, obtained from the system clock through a clock enable.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low)
- PIX_DELAY, 2, alignment depth in pixel ticks; used only with VGA_PIX_DELAY_EN

Ports:
- CLK  in  1  system clock; single clock domain
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  pixel-tick clock enable; state advances only on CLK edges with ENABLE=1
- X_CUR_COORD  out  10  horizontal counter, 0..H_TOTAL-1
- Y_CUR_COORD  out  10  vertical counter, 0..V_TOTAL-1
- VIDEO_ON  out  1  1 when X<H_DISPLAY and Y<V_DISPLAY
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- BLANK_N  out  1  DAC blank, active-low (equals VIDEO_ON, subject to delay option)
- FRAME_START  out  1  one-CLK pulse at frame wrap

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must be ≤1024; elaboration error otherwise.
- Reset (async, immediate):
  - X=0, Y=0, VIDEO_ON=1, BLANK_N=1, FRAME_START=0.
  - HSYNC/VSYNC at their inactive level (!SYNC_POL).
  - Delay-line contents cleared to the same values.
- Counting, on each CLK edge with ENABLE=1:
  - X<H_TOTAL-1: X+1.
  - Otherwise X=0, and Y advances: Y<V_TOTAL-1 ? Y+1 : 0.
- ENABLE=0: every register holds, except FRAME_START, which clears.
- Output timing:
  - X/Y are registered counters.
  - VIDEO_ON, HSYNC, VSYNC and BLANK_N are registered decodes that always describe the X/Y value presented in the same cycle (zero skew, no combinational path from counters).
- Sync windows:
  - HSYNC active for X in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - VSYNC active for Y in [490,491], over whole lines.
- FRAME_START:
  - Set on the edge where (X,Y) goes (H_TOTAL-1,V_TOTAL-1) → (0,0); cleared on the next CLK edge regardless of ENABLE.
  - Not asserted for the post-reset (0,0).
- Period: H_TOTAL*V_TOTAL = 420000 enabled ticks between FRAME_START pulses.
- Reset mid-frame: all outputs return to reset values asynchronously. Counting restarts from (0,0) on the first enabled edge after deassertion, producing (1,0).

Optional Feature:
- Macro: VGA_PIX_DELAY_EN.
- Defined: HSYNC, VSYNC and BLANK_N pass through a PIX_DELAY-deep shift register advanced on ENABLE. They lag X/Y by PIX_DELAY pixel ticks, matching frame-buffer read latency. VIDEO_ON and FRAME_START stay undelayed.
- Undefined: no delay line; all outputs aligned to X/Y; PIX_DELAY is ignored.

Decomposition:
- Package vga_pkg:
  - default 640x480 timing constants
  - derived H_TOTAL/V_TOTAL
  - coordinate width (10)
  - sync-polarity constants
- Sub-module vga_delay_line (parameterised width/depth, enable-gated shift register, async reset value input). Instantiated only under VGA_PIX_DELAY_EN.

Test Plan:
- Counting and line length: RESET pulse, ENABLE=1 constant -> X counts 0..799 then 0, Y increments only at that wrap; Y wraps 524→0.
- Horizontal sync and blank: HSYNC=0 exactly for X=656..751 (96 ticks); BLANK_N=0 for X≥640 or Y≥480.
- Vertical sync and frame period: VSYNC=0 for all of lines 490 and 491; FRAME_START pulses are 420000 CLKs apart, each 1 CLK wide.
- Clock enable: ENABLE alternating 1/0 -> counters hold on ENABLE=0 cycles; FRAME_START spacing becomes 840000 CLKs and each pulse stays 1 CLK wide.
- Reset mid-frame: assert RESET at (300,200) between edges -> X=0, Y=0, HSYNC=VSYNC=1 immediately. After release, the first enabled edge gives (1,0) and no FRAME_START.
- Delay option: with VGA_PIX_DELAY_EN and PIX_DELAY=2 -> HSYNC falls when X=658 and rises at X=754; BLANK_N falls at X=642.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants, sync/blank bundle type and polarity helpers.
// Defaults describe 640x480@60 Hz at a 25 MHz pixel tick.
package vga_pkg;

  localparam int COORD_W         = 10;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int PIX_DELAY_DEF = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } vga_sync_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  function automatic vga_sync_t sync_idle(input logic pol);
    vga_sync_t s;
    s.hsync   = ~pol;
    s.vsync   = ~pol;
    s.blank_n = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/blank with frame-buffer read
// latency; every stage resets to rst_val.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 1) begin : g_depth_err
    $error("vga_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= rst_val;
      end
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator with registered, zero-skew sync/blank decodes.
// Define VGA_PIX_DELAY_EN to delay HSYNC/VSYNC/BLANK_N by PIX_DELAY pixel ticks.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY = H_DISPLAY_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_DISPLAY = V_DISPLAY_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int   PIX_DELAY = PIX_DELAY_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  output logic [COORD_W-1:0] X_CUR_COORD,
  output logic [COORD_W-1:0] Y_CUR_COORD,
  output logic               VIDEO_ON,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               BLANK_N,
  output logic               FRAME_START
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > COORD_MAX_TOTAL) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > COORD_MAX_TOTAL) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL exceeds coordinate range");
  end
  if (PIX_DELAY < 0) begin : g_pix_delay_err
    $error("vga_timing_gen: PIX_DELAY must not be negative");
  end

  localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_END    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS_END    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] H_SYNC_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam vga_sync_t SYNC_IDLE = sync_idle(SYNC_POL);

  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] x_next, y_next;
  logic               frame_wrap;
  logic               h_active, v_active;
  logic               video_q, video_next;
  logic               frame_q;
  vga_sync_t          sync_q, sync_next;

  always_comb begin
    x_next     = x_q;
    y_next     = y_q;
    frame_wrap = 1'b0;
    if (x_q < H_LAST) begin
      x_next = x_q + 1'b1;
    end else begin
      x_next = '0;
      if (y_q < V_LAST) begin
        y_next = y_q + 1'b1;
      end else begin
        y_next     = '0;
        frame_wrap = 1'b1;
      end
    end
  end

  // Decode the upcoming coordinate so the registered flags line up with X/Y.
  always_comb begin
    h_active          = (x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST);
    v_active          = (y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST);
    video_next        = (x_next < H_VIS_END) && (y_next < V_VIS_END);
    sync_next         = SYNC_IDLE;
    sync_next.hsync   = sync_level(h_active, SYNC_POL);
    sync_next.vsync   = sync_level(v_active, SYNC_POL);
    sync_next.blank_n = video_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_q     <= '0;
      y_q     <= '0;
      video_q <= 1'b1;
      sync_q  <= SYNC_IDLE;
      frame_q <= 1'b0;
    end else begin
      frame_q <= ENABLE & frame_wrap;
      if (ENABLE) begin
        x_q     <= x_next;
        y_q     <= y_next;
        video_q <= video_next;
        sync_q  <= sync_next;
      end
    end
  end

  assign X_CUR_COORD = x_q;
  assign Y_CUR_COORD = y_q;
  assign VIDEO_ON    = video_q;
  assign FRAME_START = frame_q;

`ifdef VGA_PIX_DELAY_EN
  logic [$bits(vga_sync_t)-1:0] sync_dly;

  vga_delay_line #(
    .WIDTH ($bits(vga_sync_t)),
    .DEPTH (PIX_DELAY)
  ) u_sync_dly (
    .clk     (CLK),
    .rst     (RESET),
    .en      (ENABLE),
    .rst_val (SYNC_IDLE),
    .din     (sync_q),
    .dout    (sync_dly)
  );

  vga_sync_t sync_out;
  assign sync_out = vga_sync_t'(sync_dly);
  assign HSYNC    = sync_out.hsync;
  assign VSYNC    = sync_out.vsync;
  assign BLANK_N  = sync_out.blank_n;
`else
  assign HSYNC   = sync_q.hsync;
  assign VSYNC   = sync_q.vsync;
  assign BLANK_N = sync_q.blank_n;
`endif

endmodule
